lsr_tx: RTL and testbench
=========================

Name: lsr_tx

Overview:
- Parallel-in, serial-out framed transmitter. It is the sending end of the serial-shift path that the right-shift receiver consumes.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out MSB-first by left shift on l_out, framed as: start bit, data bits, optional even-parity bit, stop bit.
- One bit advances per shift_en strobe, which comes from an external bit-rate divider.

Parameters:
- WIDTH, 8, data word width in bits (≥2).
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; asserting low forces reset state immediately; release is synchronous to clk.
- load_valid  input  1  producer has a word on load_data.
- load_ready  output  1  transmitter can accept a word this cycle.
- load_data  input  WIDTH  word to transmit; sampled only on handshake.
- shift_en  input  1  single-cycle bit-rate strobe.
- l_out  output  1  serial line, registered, idle level 1.
- busy  output  1  frame in progress (state ≠ IDLE).
- done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, l_out=1, load_ready=1, busy=0, done=0.
  - Shift register and bit counter cleared.
  - Applies mid-frame too: the frame is aborted and no done pulse is produced.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - load_ready=1.
  - Handshake (load_valid & load_ready) at edge N: shreg←load_data, parity←^load_data, cnt←0, state←START, l_out←0.
  - From cycle N+1: load_ready=0, busy=1.
  - shift_en in IDLE is ignored, including when it coincides with a handshake.
- START: on shift_en, l_out←shreg[WIDTH-1], shreg←shreg<<1, state←DATA.
- DATA:
  - On shift_en with cnt<WIDTH-1: l_out←shreg[WIDTH-1], shift, cnt←cnt+1.
  - On shift_en with cnt==WIDTH-1:
    - If PARITY_EN: l_out←parity, state←PARITY.
    - Otherwise: l_out←1, state←STOP.
- PARITY: on shift_en, l_out←1, state←STOP.
- STOP: on shift_en, state←IDLE, done=1 for exactly the following cycle, l_out stays 1, load_ready=1 in that same cycle.
- Bit timing: each bit (start, data, parity, stop) is held on l_out for exactly one shift_en interval. The first interval runs from handshake to the first shift_en.
- load_valid while busy: ignored; load_data is not sampled.
- Back-to-back frames: a handshake in the done cycle is legal. The next start bit begins with no extra idle bit beyond the stop bit.
- Counter width: $clog2(WIDTH). No wrap past WIDTH-1.
- Parity is even: the count of 1s across data bits plus the parity bit is even.
- Frame length in shift_en strobes: WIDTH+2+PARITY_EN.

Decomposition:
- Shared package lsr_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- One natural sub-module, lsr_core: WIDTH-bit shift register with synchronous load and shift-left enable, MSB tap output, asynchronous active-low clear.
- FSM, counter and parity logic stay in lsr_tx.

Test Plan:
- Reset:
  - Hold rst=0 for 2 cycles with clk running, then release: l_out=1, load_ready=1, busy=0, done=0.
  - Drive rst low asynchronously between edges: outputs return to reset values before the next edge.
- Basic frame (WIDTH=8, PARITY_EN=1, shift_en=1 every cycle, load 0xA5):
  - l_out sequence from cycle after handshake: 0,1,0,1,0,0,1,0,1,0,1.
  - done high exactly one cycle after the stop bit; 11 bit-times total.
- Odd parity data with slow strobe (load 0x07, shift_en every 4th cycle):
  - Parity bit = 1.
  - Every bit held exactly 4 cycles.
  - busy high for 44 cycles after handshake.
- PARITY_EN=0, load 0xFF: sequence 0, eight 1s, 1 (stop); 10 bit-times; no parity slot.
- Ignore/concurrency:
  - load_valid=1 with 0x3C held continuously through a 0xA5 frame: 0x3C accepted only in the done cycle, then transmitted back-to-back.
  - shift_en asserted in the handshake cycle: start bit still lasts one full interval.
- Reset mid-frame: assert rst low during data bit 4 of 0xA5: l_out=1 immediately, no done pulse; a new 0x5A load after release transmits correctly.

Source files
------------

// File: rtl/lsr_pkg.sv
// rtl/lsr_pkg.sv - shared state type and line levels for the framed serial transmitter
package lsr_pkg;

    // Frame phases, in the order the line walks through them.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/lsr_tx_if.sv
// rtl/lsr_tx_if.sv - word load handshake between a producer and the transmitter
//
// Signals:
//   valid  producer has a word on data
//   ready  transmitter can accept a word this cycle
//   data   WIDTH-bit word, sampled only on valid & ready
interface lsr_tx_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lsr_core.sv
// rtl/lsr_core.sv - left-shifting word register with load, shift enable and MSB tap
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-low clear
//   load   synchronous parallel load of data (wins over shift)
//   shift  shift left by one, zero fill
//   data   parallel load value
//   msb    current most significant bit
module lsr_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= data;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/lsr_tx.sv
// rtl/lsr_tx.sv - framed parallel-in serial-out transmitter (start, data MSB-first, even parity, stop)
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   load      word handshake (slave side)
//   shift_en  one-cycle bit-rate strobe; one line bit per strobe
//   l_out     registered serial line, idles high
//   busy      frame in progress
//   done      one-cycle pulse after the stop bit completes
module lsr_tx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic    clk,
    input  logic    rst,
    lsr_tx_if.slave load,
    input  logic    shift_en,
    output logic    l_out,
    output logic    busy,
    output logic    done
);
    import lsr_pkg::*;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          parity;
    logic          msb;
    logic          take;
    logic          core_shift;

    assign load.ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign take       = (state == IDLE) && load.valid;

    // The register shifts each time a data bit is moved onto the line; the
    // last data bit leaves on the strobe that moves into PARITY/STOP, so no
    // shift is needed there.
    assign core_shift = shift_en &&
                        ((state == START) || ((state == DATA) && (cnt != LAST)));

    lsr_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (take),
        .shift (core_shift),
        .data  (load.data),
        .msb   (msb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            l_out  <= IDLE_LEVEL;
            cnt    <= '0;
            parity <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // shift_en is deliberately not looked at here, so the
                    // start bit always gets a full strobe interval.
                    if (load.valid) begin
                        parity <= ^load.data;
                        cnt    <= '0;
                        l_out  <= START_LEVEL;
                        state  <= START;
                    end
                end
                START: begin
                    if (shift_en) begin
                        l_out <= msb;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (shift_en) begin
                        if (cnt == LAST) begin
                            if (PARITY_EN) begin
                                l_out <= parity;
                                state <= PARITY;
                            end else begin
                                l_out <= STOP_LEVEL;
                                state <= STOP;
                            end
                        end else begin
                            l_out <= msb;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (shift_en) begin
                        l_out <= STOP_LEVEL;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (shift_en) begin
                        l_out <= STOP_LEVEL;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    l_out <= IDLE_LEVEL;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsr_tx.sv
// tb/tb_lsr_tx.sv - self-checking bench for lsr_tx with and without the parity slot
module tb_lsr_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       shift_en = 1'b0;

    always #5 clk = ~clk;

    lsr_tx_if #(.WIDTH(8)) if_p ();
    lsr_tx_if #(.WIDTH(8)) if_n ();

    assign if_p.valid = load_valid;
    assign if_p.data  = load_data;
    assign if_n.valid = load_valid;
    assign if_n.data  = load_data;

    logic l_out_p, busy_p, done_p;
    logic l_out_n, busy_n, done_n;

    lsr_tx #(.WIDTH(8), .PARITY_EN(1'b1)) dut_p (
        .clk      (clk),
        .rst      (rst),
        .load     (if_p),
        .shift_en (shift_en),
        .l_out    (l_out_p),
        .busy     (busy_p),
        .done     (done_p)
    );

    lsr_tx #(.WIDTH(8), .PARITY_EN(1'b0)) dut_n (
        .clk      (clk),
        .rst      (rst),
        .load     (if_n),
        .shift_en (shift_en),
        .l_out    (l_out_n),
        .busy     (busy_n),
        .done     (done_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Frame model: a frame is a list of line bits; position advances once per
    // strobe while a frame is active, and the frame ends after its last bit.
    bit         m_act  [2];
    int         m_pos  [2];
    logic [7:0] m_dat  [2];
    bit         m_done [2];

    function automatic int flen(input int k);
        return (k == 0) ? 11 : 10;
    endfunction

    function automatic logic fbit(input logic [7:0] d, input int pos, input int k);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return d[3'(8 - pos)];
        if (k == 0 && pos == 9) return ^d;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_act[k]  = 1'b0;
                m_pos[k]  = 0;
                m_done[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] = 1'b0;
                if (m_act[k]) begin
                    if (shift_en) begin
                        m_pos[k]++;
                        if (m_pos[k] == flen(k)) begin
                            m_act[k]  = 1'b0;
                            m_done[k] = 1'b1;
                        end
                    end
                end else if (load_valid) begin
                    m_act[k] = 1'b1;
                    m_pos[k] = 0;
                    m_dat[k] = load_data;
                end
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("l_out_p", l_out_p, m_act[0] ? fbit(m_dat[0], m_pos[0], 0) : 1'b1);
            chk("busy_p",  busy_p,  m_act[0]);
            chk("done_p",  done_p,  m_done[0]);
            chk("ready_p", if_p.ready, !m_act[0]);
            chk("l_out_n", l_out_n, m_act[1] ? fbit(m_dat[1], m_pos[1], 1) : 1'b1);
            chk("busy_n",  busy_n,  m_act[1]);
            chk("done_n",  done_n,  m_done[1]);
            chk("ready_n", if_n.ready, !m_act[1]);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    logic [23:0] sv;
    logic [23:0] dv;
    int          bcnt_p, bcnt_n, dcnt;
    logic        par_bit;

    initial begin
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_l_out", l_out_p, 1'b1);
        chk("rst_ready", if_p.ready, 1'b1);
        chk("rst_busy",  busy_p, 1'b0);
        chk("rst_done",  done_p, 1'b0);

        // Basic 0xA5 frame, strobe every cycle (also strobe in handshake cycle).
        load_valid = 1'b1; load_data = 8'hA5; shift_en = 1'b1;
        sv = '0; dv = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            sv = {sv[22:0], l_out_p};
            dv = {dv[22:0], done_p};
        end
        chk("basic_seq",  sv[11:0], 12'b010100101011);
        chk("basic_done", dv[11:0], 12'b000000000001);
        repeat (4) @(negedge clk);

        // 0x07 with a strobe every 4th cycle.
        shift_en = 1'b0; load_valid = 1'b1; load_data = 8'h07;
        sv = '0; bcnt_p = 0; bcnt_n = 0; par_bit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            bcnt_p += int'(busy_p);
            bcnt_n += int'(busy_n);
            if ((i % 4) == 1 && i < 44) sv = {sv[22:0], l_out_p};
            if (i == 38) par_bit = l_out_p;
            shift_en = ((i % 4) == 3);
        end
        chk("slow_seq",    sv[10:0], 11'b00000011111);
        chk("slow_parity", par_bit, 1'b1);
        chk("slow_busy_p", bcnt_p, 44);
        chk("slow_busy_n", bcnt_n, 40);

        // 0xFF on the no-parity transmitter.
        load_valid = 1'b1; load_data = 8'hFF; shift_en = 1'b1;
        sv = '0; dv = '0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            sv = {sv[22:0], l_out_n};
            dv = {dv[22:0], done_n};
        end
        chk("nopar_seq",  sv[10:0], 11'b01111111111);
        chk("nopar_done", dv[10:0], 11'b00000000001);
        repeat (4) @(negedge clk);

        // 0x3C held valid through an 0xA5 frame: accepted in the done cycle.
        load_valid = 1'b1; load_data = 8'hA5; shift_en = 1'b1;
        sv = '0; dv = '0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            load_data = 8'h3C;
            if (i == 12) load_valid = 1'b0;
            sv = {sv[22:0], l_out_p};
            dv = {dv[22:0], done_p};
        end
        chk("b2b_seq",  sv, 24'b010100101011000111100011);
        chk("b2b_done", dv, 24'b000000000001000000000001);
        repeat (4) @(negedge clk);

        // Reset during data bit 4 of 0xA5, then a clean 0x5A frame.
        load_valid = 1'b1; load_data = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_l_out", l_out_p, 1'b1);
        chk("async_busy",  busy_p, 1'b0);
        chk("async_ready", if_p.ready, 1'b1);
        chk("async_done",  done_p, 1'b0);
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dcnt += int'(done_p) + int'(done_n);
        end
        chk("abort_no_done", dcnt, 0);
        rst = 1'b1; load_valid = 1'b1; load_data = 8'h5A;
        sv = '0; dv = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            sv = {sv[22:0], l_out_p};
            dv = {dv[22:0], done_p};
        end
        chk("after_rst_seq",  sv[11:0], 12'b001011010011);
        chk("after_rst_done", dv[11:0], 12'b000000000001);
        repeat (4) @(negedge clk);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
